// File: rtl/wb_port_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter_if
// Description : Bundle of writeback, MDU and register-file write-port signals
//               shared by the write-port arbiter and its environment.
//   ans_wb/wb_rd/wb_we        writeback-stage request (held while stall_wb=1)
//   mdu_valid/mdu_rd/mdu_data MDU result offer, accepted when mdu_ready=1
//   mdu_ready                 FIFO has room (pend_cnt < 2)
//   stall_wb                  writeback must hold this cycle
//   rf_we/rf_waddr/rf_wdata   registered register-file write port
//   pend_cnt                  registered FIFO occupancy (0..2)
//   Modports: slave = arbiter side, master = environment side.
// Revision    : 1.0  initial release
// ============================================================================
interface wb_port_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic [DATA_W-1:0] ans_wb;
  logic [ADDR_W-1:0] wb_rd;
  logic              wb_we;
  logic              mdu_valid;
  logic [ADDR_W-1:0] mdu_rd;
  logic [DATA_W-1:0] mdu_data;
  logic              mdu_ready;
  logic              stall_wb;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [1:0]        pend_cnt;

  modport slave (
    input  ans_wb, wb_rd, wb_we, mdu_valid, mdu_rd, mdu_data,
    output mdu_ready, stall_wb, rf_we, rf_waddr, rf_wdata, pend_cnt
  );

  modport master (
    output ans_wb, wb_rd, wb_we, mdu_valid, mdu_rd, mdu_data,
    input  mdu_ready, stall_wb, rf_we, rf_waddr, rf_wdata, pend_cnt
  );
endinterface
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Shares the single register-file write port between the
//               writeback stage (priority) and the multiply/divide unit.
//               MDU results queue in a 2-entry FIFO; after STARVE_MAX cycles
//               of the FIFO head being blocked by writeback, writeback is
//               stalled for one cycle and the head is written instead.
// Ports       : clk   - clock, rising edge
//               reset - asynchronous, active-low
//               bus   - wb_port_arbiter_if.slave (requests, write port, status)
// Revision    : 1.0  initial release
// ============================================================================
module wb_port_arbiter #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 3,
  parameter int STARVE_MAX = 4
) (
  input  wire logic          clk,
  input  wire logic          reset,
  wb_port_arbiter_if.slave   bus
);

  localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_MAX);

  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_FORCE  = 1'b1
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_wcnt, w_wcnt_nxt;

  // FIFO storage, pointers and occupancy
  logic [ADDR_W-1:0] r_fifo_rd   [2];
  logic [DATA_W-1:0] r_fifo_data [2];
  logic              r_rd_ptr, r_wr_ptr;
  logic [1:0]        r_cnt;

  logic              r_stall, r_rf_we;
  logic [ADDR_W-1:0] r_rf_waddr;
  logic [DATA_W-1:0] r_rf_wdata;

  logic              w_ready, w_push, w_pop, w_grant, w_grant_wb;
  logic [ADDR_W-1:0] w_gnt_rd;
  logic [DATA_W-1:0] w_gnt_data;

  // Ready depends on registered occupancy only: no mdu_valid -> mdu_ready path.
  assign w_ready = (r_cnt != 2'd2);
  assign w_push  = bus.mdu_valid && w_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_pop       = 1'b0;
    w_grant     = 1'b0;
    w_grant_wb  = 1'b0;
    case (r_state)
      ST_NORMAL: begin
        if (bus.wb_we) begin
          w_grant    = 1'b1;
          w_grant_wb = 1'b1;
          // Only cycles where an MDU result is actually waiting count as blocked.
          if (r_cnt != 2'd0) begin
            w_wcnt_nxt = r_wcnt + 4'd1;
            if (w_wcnt_nxt == C_STARVE_MAX) begin
              w_state_nxt = ST_FORCE;
            end
          end
        end else if (r_cnt != 2'd0) begin
          w_grant    = 1'b1;
          w_pop      = 1'b1;
          w_wcnt_nxt = 4'd0;
        end
      end
      ST_FORCE: begin
        // FIFO is non-empty here by construction; wb_we is ignored.
        w_grant     = 1'b1;
        w_pop       = 1'b1;
        w_wcnt_nxt  = 4'd0;
        w_state_nxt = ST_NORMAL;
      end
      default: begin
        w_state_nxt = ST_NORMAL;
        w_wcnt_nxt  = 4'd0;
      end
    endcase
  end

  assign w_gnt_rd   = w_grant_wb ? bus.wb_rd  : r_fifo_rd[r_rd_ptr];
  assign w_gnt_data = w_grant_wb ? bus.ans_wb : r_fifo_data[r_rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_NORMAL;
      r_wcnt         <= 4'd0;
      r_stall        <= 1'b0;
      r_rd_ptr       <= 1'b0;
      r_wr_ptr       <= 1'b0;
      r_cnt          <= 2'd0;
      r_fifo_rd[0]   <= '0;
      r_fifo_rd[1]   <= '0;
      r_fifo_data[0] <= '0;
      r_fifo_data[1] <= '0;
      r_rf_we        <= 1'b0;
      r_rf_waddr     <= '0;
      r_rf_wdata     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      // stall_wb is high exactly during the FORCE cycle.
      r_stall <= (w_state_nxt == ST_FORCE);
      if (w_push) begin
        r_fifo_rd[r_wr_ptr]   <= bus.mdu_rd;
        r_fifo_data[r_wr_ptr] <= bus.mdu_data;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_cnt   <= r_cnt + 2'(w_push) - 2'(w_pop);
      // An r0 grant still consumes the slot but never enables the write.
      r_rf_we <= w_grant && (w_gnt_rd != '0);
      if (w_grant) begin
        r_rf_waddr <= w_gnt_rd;
        r_rf_wdata <= w_gnt_data;
      end
    end
  end

  assign bus.mdu_ready = w_ready;
  assign bus.stall_wb  = r_stall;
  assign bus.rf_we     = r_rf_we;
  assign bus.rf_waddr  = r_rf_waddr;
  assign bus.rf_wdata  = r_rf_wdata;
  assign bus.pend_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the pipeline writeback stage and the multi-cycle multiply/divide unit (MDU). The writeback-stage result (`ans_wb`) has priority. MDU results wait in a 2-entry FIFO, and an anti-starvation counter stalls writeback for one cycle when an MDU result has waited too long. The block sits between the writeback stage, the MDU and the register file of the 16-bit MIPS core.

## Interface
- `DATA_W`, 16: write data width
- `ADDR_W`, 3: register address width (8 registers; r0 hard-wired zero)
- `STARVE_MAX`, 4: consecutive blocked cycles before a forced MDU grant (range 1..15)

- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low; clears all state immediately
- `ans_wb`  in  DATA_W  writeback-stage result
- `wb_rd`  in  ADDR_W  writeback destination register
- `wb_we`  in  1  writeback write request; upstream holds `ans_wb`/`wb_rd`/`wb_we` while `stall_wb`=1
- `mdu_valid`  in  1  MDU result valid
- `mdu_rd`  in  ADDR_W  MDU destination register
- `mdu_data`  in  DATA_W  MDU result
- `mdu_ready`  out  1  FIFO can accept (pending count < 2); combinational from registered count only
- `stall_wb`  out  1  registered; writeback stage must hold this cycle
- `rf_we`  out  1  registered register-file write enable
- `rf_waddr`  out  ADDR_W  registered write address
- `rf_wdata`  out  DATA_W  registered write data
- `pend_cnt`  out  2  registered FIFO occupancy (0..2)

## Operation
- **FIFO.** 2 entries of {rd, data}.
  - Push when `mdu_valid && mdu_ready`.
  - Pop when the head is granted.
  - Push and pop in the same cycle are allowed; the count stays the same.
  - No push is possible when full, because `mdu_ready`=0.
- **State machine.** Two states: NORMAL and FORCE. Wait counter `wcnt` is 4 bits.
- **NORMAL:**
  - If `wb_we`=1, grant writeback.
    - If the FIFO is non-empty at the same time, `wcnt`++.
    - If the incremented value equals STARVE_MAX, next state is FORCE.
  - Else if the FIFO is non-empty, grant the FIFO head, pop it, and set `wcnt`=0.
  - Else no grant and `rf_we`=0 next cycle.
- **FORCE:**
  - `stall_wb`=1 for exactly this cycle.
  - Grant the FIFO head (non-empty by construction), pop it, set `wcnt`=0, and return to NORMAL.
  - `wb_we` is ignored this cycle; upstream re-presents it next cycle.
- **Write port.** A granted request loads `rf_waddr`/`rf_wdata` at the next edge.
  - `rf_we` is 1 only if the granted rd ≠ 0.
  - An r0 write still consumes the grant (and the pop, for the MDU) but produces `rf_we`=0.
- **Ordering.** MDU entries leave in push order. Issue logic guarantees no write-after-write (WAW) conflict between pending MDU entries and in-flight writeback writes; this block does not check for one.
- **Mid-operation reset.** Reset at any time empties the FIFO, drops any pending entries, and returns to NORMAL with `wcnt`=0.

## Timing
- **Reset values:** `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `stall_wb`=0, `pend_cnt`=0, `mdu_ready`=1, state NORMAL, `wcnt`=0.
- **Writeback latency:** request in cycle k, register-file write visible after edge k+1.
- **MDU latency:**
  - Push at edge k makes the entry the head in cycle k+1.
  - If granted there, `rf_we` is high after edge k+2.
  - There is no FIFO bypass.
- **`stall_wb` timing:** rises after the edge on which the STARVE_MAX-th blocked cycle completes, and falls after the following edge.
- **Back-to-back FORCE:** allowed after one NORMAL cycle if `wcnt` reaches STARVE_MAX again.
  - With STARVE_MAX=1, FORCE alternates with NORMAL under continuous `wb_we`.
  - Writeback throughput in that case is ≥ 50%.
- **`mdu_ready`:** depends only on registered `pend_cnt`, so there is no combinational path from `mdu_valid` to `mdu_ready`.

## Test plan
- **Reset:** assert `reset`=0 mid-stream with `pend_cnt`=2 → all outputs clear immediately, `mdu_ready`=1; after release, the first `wb_we` (rd=2, `ans_wb`=16'h0003) gives `rf_we`=1, `rf_waddr`=2, `rf_wdata`=16'h0003 one edge later.
- **Idle MDU:** `wb_we`=0, MDU pushes rd=5, data=16'h0023 at edge k → `rf_we`=1, `rf_waddr`=5, `rf_wdata`=16'h0023 after edge k+2; `pend_cnt` goes 1 then 0.
- **Starvation:** continuous `wb_we` plus one MDU entry, STARVE_MAX=4 → 4 writeback writes, then `stall_wb`=1 for one cycle, then the MDU write appears, then writeback resumes with the held value.
- **Full FIFO:** 3 consecutive MDU pushes while `wb_we`=1 → `mdu_ready`=0 after 2 pushes; the third is accepted only after a pop; `pend_cnt` never exceeds 2.
- **r0 writes:** MDU rd=0, data=16'hFFFF with `wb_we`=0 → entry popped, `pend_cnt` decrements, `rf_we` stays 0.
- **Simultaneous push/pop:** with `pend_cnt`=1 and `wb_we`=0, a push and a head grant in the same cycle → `pend_cnt` stays 1, and the head is written before the new entry.
